// File: rtl/conv_11_mc.sv
// conv_11_mc: streaming 1x1 convolution over CIN channels per pixel, with bias, shift and
// signed saturation. Define CONV_11_MC_RELU_EN to clamp negative results to zero.
module conv_11_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int CIN        = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int SHIFT      = 0,
  parameter int D          = 220
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [DATA_WIDTH-1:0]           in_data,
  input  logic                                   w_we,
  input  logic [((CIN > 1) ? $clog2(CIN) : 1)-1:0] w_addr,
  input  logic signed [DATA_WIDTH-1:0]           w_data,
  input  logic signed [ACC_WIDTH-1:0]            bias,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [DATA_WIDTH-1:0]           out_data,
  output logic                                   out_last,
  output logic                                   state_dbg
);

  localparam int CW     = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int NPIX   = D * D;
  localparam int PW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int SAT_HI = (1 << (DATA_WIDTH - 1)) - 1;

  localparam logic [CW-1:0] CHAN_LAST = CW'(CIN - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(SAT_HI);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-SAT_HI - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_LAST = 1'b1
  } state_t;

  // With a single channel every beat closes a pixel.
  localparam state_t ST_RESET = (CIN == 1) ? ST_LAST : ST_ACC;

  // Handshake: a beat moves when in_valid && in_ready, a result moves when
  // out_valid && out_ready; in_ready drops only while a result is stalled.
  state_t                      state_q, state_d;
  logic [CW-1:0]               chan_q, chan_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [PW-1:0]               pix_q;
  logic signed [DATA_WIDTH-1:0] w_mem [CIN];

  logic                        accept, out_hs;
  logic signed [ACC_WIDTH-1:0] prod_ext, acc_sum, sum, shifted, clipped;
  logic signed [DATA_WIDTH-1:0] result;

  assign in_ready  = !(out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign out_last  = out_valid && (pix_q == PIX_LAST);
  assign state_dbg = (state_q == ST_LAST);

  // Weights have no reset; a write lands at the edge, so a beat in the same
  // cycle still multiplies by the previous weight.
  always_ff @(posedge clk) begin
    if (w_we && (int'(w_addr) < CIN)) begin
      w_mem[w_addr] <= w_data;
    end
  end

  always_comb begin
    prod_ext = ACC_WIDTH'(in_data) * ACC_WIDTH'(w_mem[chan_q]);
    acc_sum  = acc_q + prod_ext;
    sum      = acc_sum + bias;
    shifted  = sum >>> SHIFT;
    clipped  = shifted;
`ifdef CONV_11_MC_RELU_EN
    if (shifted[ACC_WIDTH-1]) begin
      clipped = '0;
    end
`endif
    if (clipped > SAT_MAX) begin
      clipped = SAT_MAX;
    end else if (clipped < SAT_MIN) begin
      clipped = SAT_MIN;
    end
    result = DATA_WIDTH'(clipped);
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    acc_d   = acc_q;
    if (accept) begin
      if (state_q == ST_LAST) begin
        chan_d = '0;
        acc_d  = '0;
      end else begin
        chan_d = chan_q + CW'(1);
        acc_d  = acc_sum;
      end
      state_d = (chan_d == CHAN_LAST) ? ST_LAST : ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      chan_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      acc_q   <= acc_d;
    end
  end

  // A result loaded in the same cycle as a handshake replaces the register
  // directly, so back-to-back results never leave a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      pix_q     <= '0;
    end else begin
      if (out_hs) begin
        pix_q <= (pix_q == PIX_LAST) ? '0 : pix_q + PW'(1);
      end
      if (accept && (state_q == ST_LAST)) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
